// File: rtl/mod_updown_counter_pkg.sv
// Shared constants and helpers for the modulo-M up/down counter.
// Optional prescaler is enabled with macro MOD_COUNTER_PRESCALE_EN.
package mod_updown_counter_pkg;

    // Boundary behaviour selected by the SATURATE parameter
    localparam int unsigned MODE_WRAP = 0;
    localparam int unsigned MODE_SAT  = 1;

    // Meaning of the updown input
    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;

    // Smallest w with 2^w >= value; clog2(1) == 0
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/mod_updown_counter_rate_divider.sv
// Prescaler for mod_updown_counter: emits a one-cycle tick on every
// PRESCALE-th enabled edge. Only built when MOD_COUNTER_PRESCALE_EN is defined.
`ifdef MOD_COUNTER_PRESCALE_EN
module mod_updown_counter_rate_divider
    import mod_updown_counter_pkg::*;
#(
    parameter int unsigned PRESCALE = 4
) (
    input  logic clock,
    input  logic resetp,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int unsigned W = (clog2(PRESCALE) > 0) ? clog2(PRESCALE) : 1;
    localparam logic [W-1:0] LastCount = W'(PRESCALE - 1);

    generate
        if (PRESCALE < 1) begin : g_bad_prescale
            $error("mod_updown_counter_rate_divider: PRESCALE must be >= 1");
        end
    endgenerate

    logic [W-1:0] div_q;

    // A clear on the same edge suppresses the tick so load always wins
    assign tick = enable && !clear && (div_q == LastCount);

    // Divider state: cleared by reset or clear, frozen while enable is low
    always_ff @(posedge clock) begin
        if (resetp || clear) begin
            div_q <= '0;
        end else if (enable) begin
            div_q <= (div_q == LastCount) ? '0 : div_q + W'(1);
        end
    end

endmodule
`endif

// File: rtl/mod_updown_counter.sv
// Modulo-M up/down counter with synchronous load, wrap/saturate modes and a
// registered terminal-count pulse.
// Macro MOD_COUNTER_PRESCALE_EN adds parameter PRESCALE and a step prescaler.
module mod_updown_counter
    import mod_updown_counter_pkg::*;
#(
    parameter int unsigned N        = 4,
    parameter int unsigned MODULUS  = 10,
    parameter int unsigned SATURATE = MODE_WRAP
`ifdef MOD_COUNTER_PRESCALE_EN
    ,
    parameter int unsigned PRESCALE = 4
`endif
) (
    input  logic         clock,
    input  logic         resetp,
    input  logic         enable,
    input  logic         updown,
    input  logic         load,
    input  logic [N-1:0] d,
    output logic [N-1:0] q,
    output logic         tc
);

    // One extra bit so MODULUS == 2^N compares and increments exactly
    localparam logic [N:0] MaxVal = (N + 1)'(MODULUS - 1);
    localparam bit         SatMode = (SATURATE == MODE_SAT);

    generate
        if (MODULUS < 2 || clog2(MODULUS) > N) begin : g_bad_modulus
            $error("mod_updown_counter: MODULUS must lie in 2..2^N");
        end
    endgenerate

    logic         step;
    logic [N-1:0] count_q, count_d;
    logic         tc_q, tc_d;
    logic [N:0]   cur_ext, next_ext;

`ifdef MOD_COUNTER_PRESCALE_EN
    mod_updown_counter_rate_divider #(
        .PRESCALE(PRESCALE)
    ) u_rate_divider (
        .clock (clock),
        .resetp(resetp),
        .clear (load),
        .enable(enable),
        .tick  (step)
    );
`else
    assign step = enable;
`endif

    // Next count and terminal-count decision; priority load > step > hold
    always_comb begin
        cur_ext  = {1'b0, count_q};
        next_ext = cur_ext;
        tc_d     = 1'b0;
        if (load) begin
            next_ext = ({1'b0, d} > MaxVal) ? MaxVal : {1'b0, d};
        end else if (step) begin
            if (updown == DIR_UP) begin
                if (cur_ext == MaxVal) begin
                    if (!SatMode) begin
                        next_ext = '0;
                        tc_d     = 1'b1;
                    end
                end else begin
                    next_ext = cur_ext + (N + 1)'(1);
                    tc_d     = SatMode && (next_ext == MaxVal);
                end
            end else begin
                if (cur_ext == '0) begin
                    if (!SatMode) begin
                        next_ext = MaxVal;
                        tc_d     = 1'b1;
                    end
                end else begin
                    next_ext = cur_ext - (N + 1)'(1);
                    tc_d     = SatMode && (next_ext == '0);
                end
            end
        end
        count_d = next_ext[N-1:0];
    end

    // Count and tc registers; reset overrides everything
    always_ff @(posedge clock) begin
        if (resetp) begin
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign q  = count_q;
    assign tc = tc_q;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed bench for mod_updown_counter: wrap (N=4,M=10), saturate (N=4,M=10)
// and power-of-two wrap (N=3,M=8) instances share one set of controls.
module tb_mod_updown_counter;

`ifdef MOD_COUNTER_PRESCALE_EN
    localparam int PS = 4;
`else
    localparam int PS = 1;
`endif

    logic       clock = 1'b0;
    logic       resetp, enable, updown, load;
    logic [3:0] d;
    logic [3:0] q_wrap, q_sat;
    logic [2:0] q_p2;
    logic       tc_wrap, tc_sat, tc_p2;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    mod_updown_counter #(
        .N(4), .MODULUS(10), .SATURATE(0)
`ifdef MOD_COUNTER_PRESCALE_EN
        , .PRESCALE(1)
`endif
    ) dut_wrap (
        .clock(clock), .resetp(resetp), .enable(enable), .updown(updown),
        .load(load), .d(d), .q(q_wrap), .tc(tc_wrap)
    );

    mod_updown_counter #(
        .N(4), .MODULUS(10), .SATURATE(1)
`ifdef MOD_COUNTER_PRESCALE_EN
        , .PRESCALE(1)
`endif
    ) dut_sat (
        .clock(clock), .resetp(resetp), .enable(enable), .updown(updown),
        .load(load), .d(d), .q(q_sat), .tc(tc_sat)
    );

    mod_updown_counter #(
        .N(3), .MODULUS(8), .SATURATE(0)
`ifdef MOD_COUNTER_PRESCALE_EN
        , .PRESCALE(PS)
`endif
    ) dut_p2 (
        .clock(clock), .resetp(resetp), .enable(enable), .updown(updown),
        .load(load), .d(d[2:0]), .q(q_p2), .tc(tc_p2)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one active edge and settle before sampling
    task automatic edge_step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int steps;
        resetp = 1'b1; enable = 1'b0; updown = 1'b1; load = 1'b0; d = '0;
        edge_step();
        edge_step();
        resetp = 1'b0;
        check("reset_q_wrap", q_wrap, 0);
        check("reset_tc_wrap", tc_wrap, 0);
        check("reset_q_sat", q_sat, 0);
        check("reset_q_p2", q_p2, 0);

        // Count up from reset: wrap 9->0 on M=10, 7->0 on M=8
        enable = 1'b1; updown = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            edge_step();
            check($sformatf("wrap_up_q[%0d]", i), q_wrap, i % 10);
            check($sformatf("wrap_up_tc[%0d]", i), tc_wrap, (i % 10 == 0) ? 1 : 0);
            steps = i / PS;
            check($sformatf("p2_up_q[%0d]", i), q_p2, steps % 8);
            check($sformatf("p2_up_tc[%0d]", i), tc_p2,
                  ((i % PS == 0) && (steps % 8 == 0)) ? 1 : 0);
        end
        check("sat_held_q", q_sat, 9);
        check("sat_held_tc", tc_sat, 0);

        // Count down from 0 in wrap mode
        updown = 1'b0;
        edge_step();
        check("wrap_dn_q0", q_wrap, 9);
        check("wrap_dn_tc0", tc_wrap, 1);
        edge_step();
        check("wrap_dn_q1", q_wrap, 8);
        check("wrap_dn_tc1", tc_wrap, 0);
        edge_step();
        check("wrap_dn_q2", q_wrap, 7);

        // Saturate: load 7, climb to 9, hold, then reverse
        enable = 1'b0; load = 1'b1; d = 4'd7;
        edge_step();
        load = 1'b0;
        check("sat_load_q", q_sat, 7);
        check("sat_load_tc", tc_sat, 0);
        enable = 1'b1; updown = 1'b1;
        edge_step();
        check("sat_up_q8", q_sat, 8);
        check("sat_up_tc8", tc_sat, 0);
        edge_step();
        check("sat_up_q9", q_sat, 9);
        check("sat_up_tc9", tc_sat, 1);
        edge_step();
        check("sat_hold_q9", q_sat, 9);
        check("sat_hold_tc9", tc_sat, 0);
        updown = 1'b0;
        edge_step();
        check("sat_rev_q", q_sat, 8);
        check("sat_rev_tc", tc_sat, 0);
        for (int v = 7; v >= 0; v--) begin
            edge_step();
            check($sformatf("sat_dn_q[%0d]", v), q_sat, v);
            check($sformatf("sat_dn_tc[%0d]", v), tc_sat, (v == 0) ? 1 : 0);
        end
        edge_step();
        check("sat_hold_q0", q_sat, 0);
        check("sat_hold_tc0", tc_sat, 0);

        // Load clamp, then load beating an enabled wrap on the same edge
        enable = 1'b0; load = 1'b1; d = 4'd12;
        edge_step();
        check("load_clamp_q", q_wrap, 9);
        check("load_clamp_tc", tc_wrap, 0);
        enable = 1'b1; updown = 1'b1; d = 4'd3;
        edge_step();
        check("load_prio_q", q_wrap, 3);
        check("load_prio_tc", tc_wrap, 0);

        // Hold while idle, then reset beats load and enable
        enable = 1'b0; d = 4'd5;
        edge_step();
        load = 1'b0;
        edge_step();
        check("idle_hold_q", q_wrap, 5);
        check("idle_hold_tc", tc_wrap, 0);
        resetp = 1'b1; load = 1'b1; enable = 1'b1; d = 4'd7;
        edge_step();
        check("reset_prio_q", q_wrap, 0);
        check("reset_prio_tc", tc_wrap, 0);
        resetp = 1'b0; load = 1'b0; enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            edge_step();
            check($sformatf("post_reset_q[%0d]", i), q_wrap, 0);
            check($sformatf("post_reset_tc[%0d]", i), tc_wrap, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
